// File: rtl/lsq_mem_issuer.sv
// ============================================================================
// Module   : lsq_mem_issuer
// Purpose  : Dequeues LSQ entries and issues them as load/store memory requests,
//            with register-file writeback of load data.
//            The optional memory watchdog is built when LSQ_ISSUER_TIMEOUT_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsq_mem_issuer #(
   parameter int NUM_PHYS_REGS  = 64,
   parameter int ENTRY_SIZE     = 1 + 1 + $clog2(NUM_PHYS_REGS) + 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic                             FLUSH,
   output logic                             Dequeue_OUT,
   input  logic                             DequeueResult_IN,
   input  logic [ENTRY_SIZE-1:0]            Entry_IN,
   output logic [$clog2(NUM_PHYS_REGS)-1:0] RegRdAddr_OUT,
   input  logic [31:0]                      RegRdData_IN,
   output logic                             MemReq_OUT,
   output logic                             MemWrite_OUT,
   output logic [31:0]                      MemAddr_OUT,
   output logic [31:0]                      MemWData_OUT,
   input  logic                             MemAck_IN,
   input  logic [31:0]                      MemRData_IN,
   output logic                             WB_Valid_OUT,
   output logic [$clog2(NUM_PHYS_REGS)-1:0] WB_Reg_OUT,
   output logic [31:0]                      WB_Data_OUT,
   output logic                             Drop_OUT,
   output logic                             Timeout_OUT
);

   localparam int LP = $clog2(NUM_PHYS_REGS);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DQ   = 3'd1,
      WAIT = 3'd2,
      RD   = 3'd3,
      REQ  = 3'd4,
      WB   = 3'd5
   } state_t;

   state_t          r_state;
   logic            r_ls;
   logic [LP-1:0]   r_reg;
   logic [31:0]     r_addr;
   logic [31:0]     r_sdata;
   logic [31:0]     r_ldata;
   logic            r_drop;

   logic            w_ent_ls;
   logic            w_ent_ready;
   logic [LP-1:0]   w_ent_reg;
   logic [31:0]     w_ent_addr;

   assign w_ent_ls    = Entry_IN[ENTRY_SIZE-1];
   assign w_ent_ready = Entry_IN[ENTRY_SIZE-2];
   assign w_ent_reg   = Entry_IN[32 +: LP];
   assign w_ent_addr  = Entry_IN[31:0];

`ifdef LSQ_ISSUER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]   r_cnt;
   logic            r_tmo;
`else
   logic            w_unused_tmo_param;
   assign w_unused_tmo_param = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= IDLE;
         r_ls    <= 1'b0;
         r_reg   <= '0;
         r_addr  <= '0;
         r_sdata <= '0;
         r_ldata <= '0;
         r_drop  <= 1'b0;
`ifdef LSQ_ISSUER_TIMEOUT_EN
         r_cnt   <= '0;
         r_tmo   <= 1'b0;
`endif
      end else begin
         r_drop <= 1'b0;
`ifdef LSQ_ISSUER_TIMEOUT_EN
         r_tmo  <= 1'b0;
`endif
         if (FLUSH) begin
            r_state <= IDLE;
`ifdef LSQ_ISSUER_TIMEOUT_EN
            r_cnt   <= '0;
`endif
         end else begin
            case (r_state)
               IDLE: r_state <= DQ;
               DQ:   r_state <= WAIT;
               WAIT: begin
                  if (DequeueResult_IN) begin
                     r_ls    <= w_ent_ls;
                     r_reg   <= w_ent_reg;
                     r_addr  <= w_ent_addr;
                     r_sdata <= '0;
                     if (!w_ent_ready) begin
                        r_drop  <= 1'b1;
                        r_state <= IDLE;
                     end else if (w_ent_ls) begin
                        r_state <= RD;
                     end else begin
                        r_state <= REQ;
                     end
                  end else begin
                     r_state <= IDLE;
                  end
               end
               RD: begin
                  r_sdata <= RegRdData_IN;
                  r_state <= REQ;
               end
               REQ: begin
                  if (MemAck_IN) begin
`ifdef LSQ_ISSUER_TIMEOUT_EN
                     r_cnt <= '0;
`endif
                     if (!r_ls) begin
                        r_ldata <= MemRData_IN;
                        r_state <= WB;
                     end else begin
                        r_state <= IDLE;
                     end
                  end
`ifdef LSQ_ISSUER_TIMEOUT_EN
                  // The current unacked cycle is the TIMEOUT_CYCLES-th when the count already holds N-1.
                  else if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                     r_cnt   <= '0;
                     r_tmo   <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
`endif
               end
               WB:      r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Every output is a decode of state and captured registers only.
   assign Dequeue_OUT   = (r_state == DQ);
   assign RegRdAddr_OUT = (r_state == RD)  ? r_reg   : '0;
   assign MemReq_OUT    = (r_state == REQ);
   assign MemWrite_OUT  = (r_state == REQ) & r_ls;
   assign MemAddr_OUT   = (r_state == REQ) ? r_addr  : '0;
   assign MemWData_OUT  = (r_state == REQ) ? r_sdata : '0;
   assign WB_Valid_OUT  = (r_state == WB);
   assign WB_Reg_OUT    = (r_state == WB)  ? r_reg   : '0;
   assign WB_Data_OUT   = (r_state == WB)  ? r_ldata : '0;
   assign Drop_OUT      = r_drop;
`ifdef LSQ_ISSUER_TIMEOUT_EN
   assign Timeout_OUT   = r_tmo;
`else
   assign Timeout_OUT   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsq_mem_issuer.sv
// ============================================================================
// Module   : tb_lsq_mem_issuer
// Purpose  : Directed self-checking bench for lsq_mem_issuer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsq_mem_issuer;

   logic        CLK;
   logic        RESET;
   logic        FLUSH;
   logic        Dequeue_OUT;
   logic        DequeueResult_IN;
   logic [39:0] Entry_IN;
   logic [5:0]  RegRdAddr_OUT;
   logic [31:0] RegRdData_IN;
   logic        MemReq_OUT;
   logic        MemWrite_OUT;
   logic [31:0] MemAddr_OUT;
   logic [31:0] MemWData_OUT;
   logic        MemAck_IN;
   logic [31:0] MemRData_IN;
   logic        WB_Valid_OUT;
   logic [5:0]  WB_Reg_OUT;
   logic [31:0] WB_Data_OUT;
   logic        Drop_OUT;
   logic        Timeout_OUT;

   int pass_cnt = 0;
   int total_cnt = 0;

`ifdef LSQ_ISSUER_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   lsq_mem_issuer #(
      .NUM_PHYS_REGS  (64),
      .ENTRY_SIZE     (40),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .FLUSH            (FLUSH),
      .Dequeue_OUT      (Dequeue_OUT),
      .DequeueResult_IN (DequeueResult_IN),
      .Entry_IN         (Entry_IN),
      .RegRdAddr_OUT    (RegRdAddr_OUT),
      .RegRdData_IN     (RegRdData_IN),
      .MemReq_OUT       (MemReq_OUT),
      .MemWrite_OUT     (MemWrite_OUT),
      .MemAddr_OUT      (MemAddr_OUT),
      .MemWData_OUT     (MemWData_OUT),
      .MemAck_IN        (MemAck_IN),
      .MemRData_IN      (MemRData_IN),
      .WB_Valid_OUT     (WB_Valid_OUT),
      .WB_Reg_OUT       (WB_Reg_OUT),
      .WB_Data_OUT      (WB_Data_OUT),
      .Drop_OUT         (Drop_OUT),
      .Timeout_OUT      (Timeout_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Register file model: reg7 holds 0x1234, everything else a tagged pattern.
   always_comb begin
      RegRdData_IN = 32'hBAD0_0000 | {26'd0, RegRdAddr_OUT};
      if (RegRdAddr_OUT == 6'd7) RegRdData_IN = 32'h0000_1234;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic wait_dq();
      int n = 0;
      while (Dequeue_OUT !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      check("dq_seen", {31'd0, Dequeue_OUT}, 32'd1);
   endtask

   initial begin
      RESET = 1'b0;
      FLUSH = 1'b0;
      DequeueResult_IN = 1'b0;
      Entry_IN = '0;
      MemAck_IN = 1'b0;
      MemRData_IN = '0;
      step();
      step();
      // Reset state
      check("rst_dq",   {31'd0, Dequeue_OUT},  32'd0);
      check("rst_req",  {31'd0, MemReq_OUT},   32'd0);
      check("rst_wb",   {31'd0, WB_Valid_OUT}, 32'd0);
      check("rst_drop", {31'd0, Drop_OUT},     32'd0);
      check("rst_tmo",  {31'd0, Timeout_OUT},  32'd0);

      // Load: {0,1,5,0x100}, ack in first REQ cycle
      DequeueResult_IN = 1'b1;
      Entry_IN = {1'b0, 1'b1, 6'd5, 32'h0000_0100};
      MemAck_IN = 1'b1;
      MemRData_IN = 32'hDEAD_BEEF;
      RESET = 1'b1;
      wait_dq();
      step();
      check("ld_wait_req", {31'd0, MemReq_OUT}, 32'd0);
      step();
      check("ld_req",   {31'd0, MemReq_OUT},   32'd1);
      check("ld_wr",    {31'd0, MemWrite_OUT}, 32'd0);
      check("ld_addr",  MemAddr_OUT,           32'h100);
      check("ld_wdata", MemWData_OUT,          32'd0);
      step();
      check("ld_wbv",   {31'd0, WB_Valid_OUT}, 32'd1);
      check("ld_wbr",   {26'd0, WB_Reg_OUT},   32'd5);
      check("ld_wbd",   WB_Data_OUT,           32'hDEAD_BEEF);
      step();
      check("ld_wb_once", {31'd0, WB_Valid_OUT}, 32'd0);

      // Store: {1,1,7,0x200}, reg7 = 0x1234, ack delayed one cycle
      Entry_IN = {1'b1, 1'b1, 6'd7, 32'h0000_0200};
      MemAck_IN = 1'b0;
      wait_dq();
      step();
      step();
      check("st_rdaddr", {26'd0, RegRdAddr_OUT}, 32'd7);
      step();
      check("st_req",   {31'd0, MemReq_OUT},   32'd1);
      check("st_wr",    {31'd0, MemWrite_OUT}, 32'd1);
      check("st_addr",  MemAddr_OUT,           32'h200);
      check("st_wdata", MemWData_OUT,          32'h1234);
      step();
      check("st_hold_req",   {31'd0, MemReq_OUT}, 32'd1);
      check("st_hold_wdata", MemWData_OUT,        32'h1234);
      check("st_hold_wb",    {31'd0, WB_Valid_OUT}, 32'd0);
      MemAck_IN = 1'b1;
      step();
      check("st_done_req", {31'd0, MemReq_OUT},   32'd0);
      check("st_no_wb",    {31'd0, WB_Valid_OUT}, 32'd0);
      MemAck_IN = 1'b0;

      // Not-ready entry is dropped
      Entry_IN = {1'b0, 1'b0, 6'd3, 32'h0000_0300};
      wait_dq();
      step();
      step();
      check("drop_pulse", {31'd0, Drop_OUT},   32'd1);
      check("drop_noreq", {31'd0, MemReq_OUT}, 32'd0);
      step();
      check("drop_once",  {31'd0, Drop_OUT},   32'd0);
      check("drop_redq",  {31'd0, Dequeue_OUT}, 32'd1);

      // Empty LSQ: Dequeue_OUT every 3 cycles
      DequeueResult_IN = 1'b0;
      step();
      check("empty_wait_dq", {31'd0, Dequeue_OUT}, 32'd0);
      step();
      check("empty_idle_dq", {31'd0, Dequeue_OUT}, 32'd0);
      step();
      check("empty_dq1", {31'd0, Dequeue_OUT}, 32'd1);
      step();
      step();
      step();
      check("empty_dq2",   {31'd0, Dequeue_OUT}, 32'd1);
      check("empty_noreq", {31'd0, MemReq_OUT},  32'd0);

      // Flush in REQ with a coincident ack
      DequeueResult_IN = 1'b1;
      Entry_IN = {1'b0, 1'b1, 6'd9, 32'h0000_0400};
      step();
      step();
      check("fl_req", {31'd0, MemReq_OUT}, 32'd1);
      FLUSH = 1'b1;
      MemAck_IN = 1'b1;
      MemRData_IN = 32'h0000_0055;
      step();
      check("fl_idle_req", {31'd0, MemReq_OUT},   32'd0);
      check("fl_no_wb",    {31'd0, WB_Valid_OUT}, 32'd0);
      FLUSH = 1'b0;
      MemAck_IN = 1'b0;
      step();
      check("fl_dq",    {31'd0, Dequeue_OUT},  32'd1);
      check("fl_no_wb2", {31'd0, WB_Valid_OUT}, 32'd0);

      // Asynchronous reset in the middle of REQ
      step();
      step();
      check("rs_req",  {31'd0, MemReq_OUT}, 32'd1);
      check("rs_addr", MemAddr_OUT,         32'h400);
      #2 RESET = 1'b0;
      #1;
      check("rs_req0",  {31'd0, MemReq_OUT},   32'd0);
      check("rs_addr0", MemAddr_OUT,           32'd0);
      check("rs_dq0",   {31'd0, Dequeue_OUT},  32'd0);
      check("rs_wb0",   {31'd0, WB_Valid_OUT}, 32'd0);
      step();
      RESET = 1'b1;

      // Ack never arrives
      wait_dq();
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         check("tmo_req_held", {31'd0, MemReq_OUT}, 32'd1);
      end
      step();
`ifdef LSQ_ISSUER_TIMEOUT_EN
      check("tmo_pulse",  {31'd0, Timeout_OUT},  32'd1);
      check("tmo_noreq",  {31'd0, MemReq_OUT},   32'd0);
      check("tmo_no_wb",  {31'd0, WB_Valid_OUT}, 32'd0);
      step();
      check("tmo_once",   {31'd0, Timeout_OUT},  32'd0);
      check("tmo_redq",   {31'd0, Dequeue_OUT},  32'd1);
`else
      check("notmo_req",   {31'd0, MemReq_OUT},  32'd1);
      check("notmo_pulse", {31'd0, Timeout_OUT}, 32'd0);
      MemAck_IN = 1'b1;
      MemRData_IN = 32'h0000_CAFE;
      step();
      check("notmo_wbv", {31'd0, WB_Valid_OUT}, 32'd1);
      check("notmo_wbd", WB_Data_OUT,           32'h0000_CAFE);
      MemAck_IN = 1'b0;
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
